sar_search: RTL and testbench

Binary-search engine that finds an unknown WIDTH-bit target value by issuing probe values to an external magnitude comparator and consuming its equal/greater/less verdicts. The block drives the probe side of the comparator interface, with the probe on operand a and the hidden target on operand b. It sits between a controller that requests a search and any comparator, combinational or multi-cycle, that answers with a valid strobe.

---
 rtl/sar_search_pkg.sv | 17 +
 rtl/sar_search_dp.sv | 57 +++++
 rtl/sar_search.sv | 145 ++++++++++++++
 tb/tb_sar_search.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/sar_search_pkg.sv
// Shared types and helpers for the sar_search binary-search engine.
package sar_search_pkg;

    localparam int unsigned SAR_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PROBE = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Midpoint of an inclusive [lo, hi] range held in WIDTH+1 bits, zero-extended to 32.
    function automatic logic [31:0] sar_mid(input logic [31:0] lo, input logic [31:0] hi);
        return lo + ((hi - lo) >> 1);
    endfunction

endpackage

// File: rtl/sar_search_dp.sv
// Search-range datapath: lo/hi bounds, registered probe and the bound-update arithmetic.
module sar_search_dp
    import sar_search_pkg::*;
#(
    parameter int unsigned WIDTH = SAR_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             upd_i,
    input  logic             gt_i,
    output logic [WIDTH-1:0] probe_o,
    output logic             empty_c_o
);

    localparam int unsigned BW = WIDTH + 1;

    logic [BW-1:0]    lo_q, hi_q, lo_d, hi_d;
    logic [BW-1:0]    probe_w;
    logic [WIDTH-1:0] probe_q;

    assign probe_w = BW'(probe_q);
    assign probe_o = probe_q;

    always_comb begin
        lo_d = lo_q;
        hi_d = hi_q;
        if (load_i) begin
            lo_d = '0;
            hi_d = {1'b0, {WIDTH{1'b1}}};
        end else if (upd_i) begin
            if (gt_i) begin
                hi_d = probe_w - BW'(1);
            end else begin
                lo_d = probe_w + BW'(1);
            end
        end
    end

    // hi = 0 - 1 would wrap to all-ones, so that underflow is flagged as empty explicitly.
    assign empty_c_o = (gt_i && (probe_q == '0)) || (lo_d > hi_d);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lo_q    <= '0;
            hi_q    <= '0;
            probe_q <= '0;
        end else begin
            lo_q <= lo_d;
            hi_q <= hi_d;
            if (load_i || (upd_i && !empty_c_o)) begin
                probe_q <= WIDTH'(sar_mid(32'(lo_d), 32'(hi_d)));
            end
        end
    end

endmodule

// File: rtl/sar_search.sv
// Binary-search engine driving an external comparator; FSM, handshake and result registers.
// Optional SAR_SEARCH_ERR_EN adds err_o and flags non-one-hot verdicts.
module sar_search
    import sar_search_pkg::*;
#(
    parameter  int unsigned WIDTH = SAR_W,
    localparam int unsigned CW    = $clog2(WIDTH + 2)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    output logic [WIDTH-1:0] probe_o,
    output logic             probe_valid_o,
    input  logic             cmp_valid_i,
    input  logic             cmp_eq_i,
    input  logic             cmp_gt_i,
    input  logic             cmp_lt_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             found_o,
    output logic [WIDTH-1:0] result_o,
    output logic [CW-1:0]    probe_cnt_o
`ifdef SAR_SEARCH_ERR_EN
    ,
    output logic             err_o
`endif
);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             found_q, found_d;
    logic             busy_q, done_q, pv_q;
    logic             load_c, upd_c, empty_c;

`ifdef SAR_SEARCH_ERR_EN
    logic             err_q, err_d;
    logic             verdict_ok_c;

    assign verdict_ok_c = $onehot({cmp_eq_i, cmp_gt_i, cmp_lt_i});
    assign err_o        = err_q;
`else
    // lt is implied whenever neither eq nor gt is set.
    logic             lt_unused_c;
    assign lt_unused_c = cmp_lt_i;
`endif

    sar_search_dp #(
        .WIDTH(WIDTH)
    ) u_dp (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (load_c),
        .upd_i    (upd_c),
        .gt_i     (cmp_gt_i),
        .probe_o  (probe_o),
        .empty_c_o(empty_c)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        found_d  = found_q;
        load_c   = 1'b0;
        upd_c    = 1'b0;
`ifdef SAR_SEARCH_ERR_EN
        err_d    = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = PROBE;
                    load_c  = 1'b1;
                    cnt_d   = '0;
                    found_d = 1'b0;
`ifdef SAR_SEARCH_ERR_EN
                    err_d   = 1'b0;
`endif
                end
            end
            PROBE: begin
                if (cmp_valid_i) begin
                    cnt_d = cnt_q + CW'(1);
`ifdef SAR_SEARCH_ERR_EN
                    if (!verdict_ok_c) begin
                        err_d    = 1'b1;
                        found_d  = 1'b0;
                        result_d = probe_o;
                        state_d  = DONE;
                    end else
`endif
                    if (cmp_eq_i) begin
                        result_d = probe_o;
                        found_d  = 1'b1;
                        state_d  = DONE;
                    end else begin
                        upd_c = 1'b1;
                        if (empty_c) begin
                            result_d = probe_o;
                            found_d  = 1'b0;
                            state_d  = DONE;
                        end
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            result_q <= '0;
            found_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pv_q     <= 1'b0;
`ifdef SAR_SEARCH_ERR_EN
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            found_q  <= found_d;
            busy_q   <= (state_d == PROBE);
            pv_q     <= (state_d == PROBE);
            done_q   <= (state_d == DONE);
`ifdef SAR_SEARCH_ERR_EN
            err_q    <= err_d;
`endif
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign probe_valid_o = pv_q;
    assign found_o       = found_q;
    assign result_o      = result_q;
    assign probe_cnt_o   = cnt_q;

endmodule

// File: tb/tb_sar_search.sv
// Self-checking bench for sar_search: directed vector table, hand sequences, random targets.
module tb_sar_search;

    localparam int W  = 4;
    localparam int CW = $clog2(W + 2);
    localparam int M_HONEST = 0, M_STUCK_LT = 1, M_EQGT = 2;

`ifdef SAR_SEARCH_ERR_EN
    localparam bit ERR_EN = 1'b1;
    logic err_o;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          clk = 1'b0, rst_n = 1'b0, start_i = 1'b0;
    logic [W-1:0]  probe_o, result_o;
    logic          probe_valid_o, busy_o, done_o, found_o;
    logic          cmp_valid_i = 1'b0, cmp_eq_i = 1'b0, cmp_gt_i = 1'b0, cmp_lt_i = 1'b0;
    logic [CW-1:0] probe_cnt_o;

    sar_search #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .probe_o      (probe_o),
        .probe_valid_o(probe_valid_o),
        .cmp_valid_i  (cmp_valid_i),
        .cmp_eq_i     (cmp_eq_i),
        .cmp_gt_i     (cmp_gt_i),
        .cmp_lt_i     (cmp_lt_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .found_o      (found_o),
        .result_o     (result_o),
        .probe_cnt_o  (probe_cnt_o)
`ifdef SAR_SEARCH_ERR_EN
        ,
        .err_o        (err_o)
`endif
    );

    always #5 clk = ~clk;

    int nchk = 0, nerr = 0;
    int mode = M_HONEST, target = 0, stall = 0, ctr = 0;
    bit pv_prev = 1'b0;
    int seen_q[$];
    int exp_q[$];
    int exp_found, exp_result, exp_err;

    task automatic check(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Comparator stub: answers `stall` cycles after each new probe appears.
    always @(negedge clk) begin
        if (!probe_valid_o || !pv_prev || cmp_valid_i) ctr = 0;
        else ctr++;
        pv_prev     = probe_valid_o;
        cmp_valid_i = probe_valid_o && (ctr >= stall);
        cmp_eq_i = 1'b0; cmp_gt_i = 1'b0; cmp_lt_i = 1'b0;
        if (cmp_valid_i) begin
            seen_q.push_back(int'(probe_o));
            case (mode)
                M_STUCK_LT: cmp_lt_i = 1'b1;
                M_EQGT: begin cmp_eq_i = 1'b1; cmp_gt_i = 1'b1; end
                default: begin
                    cmp_eq_i = (int'(probe_o) == target);
                    cmp_gt_i = (int'(probe_o) > target);
                    cmp_lt_i = (int'(probe_o) < target);
                end
            endcase
        end
    end

    // Reference: textbook binary search over plain integers.
    function automatic void model_run(input int t, input int m);
        int lo, hi, p;
        bit eq, gt;
        lo = 0; hi = (1 << W) - 1;
        exp_q.delete(); exp_err = 0; exp_found = 0; exp_result = 0;
        for (int n = 0; n < 64; n++) begin
            p = lo + (hi - lo) / 2;
            exp_q.push_back(p);
            eq = (m == M_EQGT) || (m == M_HONEST && p == t);
            gt = (m == M_EQGT) || (m == M_HONEST && p > t);
            exp_result = p;
            if (eq && gt && ERR_EN) begin exp_err = 1; return; end
            if (eq) begin exp_found = 1; return; end
            if (gt) hi = p - 1; else lo = p + 1;
            if (lo > hi) return;
        end
    endfunction

    task automatic check_reset(input string tag);
        check({tag, "_busy"}, int'(busy_o), 0);
        check({tag, "_done"}, int'(done_o), 0);
        check({tag, "_pv"}, int'(probe_valid_o), 0);
        check({tag, "_probe"}, int'(probe_o), 0);
        check({tag, "_result"}, int'(result_o), 0);
        check({tag, "_found"}, int'(found_o), 0);
        check({tag, "_cnt"}, int'(probe_cnt_o), 0);
`ifdef SAR_SEARCH_ERR_EN
        check({tag, "_err"}, int'(err_o), 0);
`endif
    endtask

    task automatic run_search(input string tag, input int t, input int m, input int st,
                              input bit start_in_done, output int edges);
        bit acc, ppv;
        int pp;
        target = t; mode = m; stall = st;
        @(negedge clk); start_i = 1'b1; seen_q.delete();
        @(posedge clk); #1; start_i = 1'b0;
        check({tag, "_busy_start"}, int'(busy_o), 1);
        check({tag, "_pv_start"}, int'(probe_valid_o), 1);
        check({tag, "_probe_first"}, int'(probe_o), 7);
        edges = 0;
        while (!done_o && edges < 500) begin
            @(posedge clk);
            acc = cmp_valid_i; pp = int'(probe_o); ppv = probe_valid_o;
            #1; edges++;
            if (ppv && !acc) begin
                check({tag, "_stall_probe"}, int'(probe_o), pp);
                check({tag, "_stall_pv"}, int'(probe_valid_o), 1);
            end
        end
        if (!done_o) begin
            check({tag, "_done_timeout"}, int'(done_o), 1);
            return;
        end
        check({tag, "_busy_done"}, int'(busy_o), 0);
        check({tag, "_pv_done"}, int'(probe_valid_o), 0);
        if (start_in_done) start_i = 1'b1;
        @(posedge clk); #1; start_i = 1'b0;
        check({tag, "_done_pulse"}, int'(done_o), 0);
        check({tag, "_idle_after"}, int'(busy_o), 0);
    endtask

    task automatic check_seq(input string tag);
        check({tag, "_seq_len"}, seen_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < seen_q.size(); i++)
            check($sformatf("%s_seq%0d", tag, i), seen_q[i], exp_q[i]);
    endtask

    typedef struct {
        int target; int mode; int stall; bit sid;
        int exp_result; int exp_found; int exp_cnt; int exp_edges;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int edges, t, st;
        string tag;

        vecs[0] = '{7,  M_HONEST,   0, 1'b0, 7,  1, 1, 1};
        vecs[1] = '{15, M_HONEST,   0, 1'b1, 15, 1, 5, 5};
        vecs[2] = '{0,  M_HONEST,   0, 1'b0, 0,  1, 4, 4};
        vecs[3] = '{9,  M_HONEST,   3, 1'b0, 9,  1, 3, 12};
        vecs[4] = '{0,  M_STUCK_LT, 0, 1'b0, 15, 0, 5, 5};
`ifdef SAR_SEARCH_ERR_EN
        vecs[5] = '{0,  M_EQGT,     0, 1'b0, 7,  0, 1, 1};
`else
        vecs[5] = '{0,  M_EQGT,     0, 1'b0, 7,  1, 1, 1};
`endif

        repeat (3) @(posedge clk);
        #1;
        check_reset("reset");
        @(negedge clk); rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            tag = $sformatf("vec%0d", i);
            run_search(tag, vecs[i].target, vecs[i].mode, vecs[i].stall, vecs[i].sid, edges);
            check({tag, "_edges"}, edges, vecs[i].exp_edges);
            check({tag, "_result"}, int'(result_o), vecs[i].exp_result);
            check({tag, "_found"}, int'(found_o), vecs[i].exp_found);
            check({tag, "_cnt"}, int'(probe_cnt_o), vecs[i].exp_cnt);
`ifdef SAR_SEARCH_ERR_EN
            check({tag, "_err"}, int'(err_o), (vecs[i].mode == M_EQGT) ? 1 : 0);
`endif
            model_run(vecs[i].target, vecs[i].mode);
            check_seq(tag);
        end

        // Reset in the middle of a search, while the third probe is pending.
        target = 15; mode = M_HONEST; stall = 0;
        @(negedge clk); start_i = 1'b1; seen_q.delete();
        @(posedge clk); #1; start_i = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("midrst_probe3", int'(probe_o), 13);
        check("midrst_cnt", int'(probe_cnt_o), 2);
        @(negedge clk); rst_n = 1'b0;
        @(posedge clk); #1;
        check_reset("midrst");
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("midrst_no_done", int'(done_o), 0);
            check("midrst_idle", int'(busy_o), 0);
        end
        run_search("post_rst", 5, M_HONEST, 0, 1'b0, edges);
        model_run(5, M_HONEST);
        check("post_rst_result", int'(result_o), 5);
        check("post_rst_found", int'(found_o), 1);
        check("post_rst_cnt", int'(probe_cnt_o), exp_q.size());
        check_seq("post_rst");

        // Random targets and comparator latencies against the reference search.
        for (int i = 0; i < 20; i++) begin
            t  = int'($urandom_range(0, 15));
            st = int'($urandom_range(0, 2));
            tag = $sformatf("rnd%0d_t%0d", i, t);
            model_run(t, M_HONEST);
            run_search(tag, t, M_HONEST, st, 1'b0, edges);
            check({tag, "_result"}, int'(result_o), exp_result);
            check({tag, "_found"}, int'(found_o), exp_found);
            check({tag, "_cnt"}, int'(probe_cnt_o), exp_q.size());
            check({tag, "_edges"}, edges, exp_q.size() * (st + 1));
            check_seq(tag);
        end

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

endmodule
